// File: rtl/loader_pkg.sv
// Shared definitions for the BRAM loader: FSM state encoding and the
// byte-order constant used when two upstream bytes are packed into a word.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GET_HI = 3'd1,
        GET_LO = 3'd2,
        WRITE  = 3'd3,
        READ   = 3'd4,
        CHECK  = 3'd5,
        DONE   = 3'd6,
        ERROR  = 3'd7
    } state_t;

    // First byte of each pair carries word[15:8].
    localparam bit BIG_ENDIAN = 1'b1;

    // Place one upstream byte into the word being assembled.
    function automatic logic [15:0] place_byte(
        input logic [15:0] word,
        input logic [7:0]  data,
        input logic        first
    );
        logic [15:0] r;
        r = word;
        if (first == BIG_ENDIAN) begin
            r[15:8] = data;
        end else begin
            r[7:0] = data;
        end
        return r;
    endfunction

endpackage

// File: rtl/bram_loader.sv
// Streams byte pairs into port B of a 16-bit BRAM, verifying each word by
// reading it back, and reports a running count and checksum of good words.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, len          begin a load of len words (clamped to the depth)
//   byte_valid/_data    upstream byte stream
//   byte_ready          byte accepted this cycle when valid is also high
//   en_b, we_b, addr_b  BRAM port B controls
//   din_b, dout_b       BRAM port B write data / registered read data
//   busy, done, error   load status (done/error are sticky levels)
//   words_written       number of verified words
//   checksum            mod-2^16 sum of verified words
module bram_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  en_b,
    output logic                  we_b,
    output logic [ADDR_WIDTH-1:0] addr_b,
    output logic [15:0]           din_b,
    input  logic [15:0]           dout_b,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_written,
    output logic [15:0]           checksum
);

    // Full memory depth expressed in the len width.
    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                state_q;
    state_t                state_d;

    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [15:0]           word_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic [15:0]           sum_q;

    logic [ADDR_WIDTH:0]   len_clamped;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  can_start;
    logic                  start_ok;
    logic                  xfer;
    logic                  match;

    assign len_clamped = (len > MAX_LEN) ? MAX_LEN : len;
    assign count_next  = count_q + 1'b1;
    assign match       = (dout_b == word_q);
    assign xfer        = byte_valid && byte_ready;

    // Only the idle-like states listen to start; a running load ignores it.
    assign can_start = (state_q == IDLE) ||
                       (state_q == DONE) ||
                       (state_q == ERROR);
    assign start_ok  = can_start && start;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    if (len_clamped == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = GET_HI;
                    end
                end
            end
            GET_HI: begin
                if (byte_valid) begin
                    state_d = GET_LO;
                end
            end
            GET_LO: begin
                if (byte_valid) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                state_d = READ;
            end
            READ: begin
                state_d = CHECK;
            end
            CHECK: begin
                if (!match) begin
                    state_d = ERROR;
                end else if (count_next == len_q) begin
                    state_d = DONE;
                end else begin
                    state_d = GET_HI;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: word assembly, pointer, count and checksum
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            word_q  <= '0;
            len_q   <= '0;
            count_q <= '0;
            sum_q   <= '0;
        end else begin
            if (start_ok) begin
                ptr_q   <= '0;
                count_q <= '0;
                sum_q   <= '0;
                len_q   <= len_clamped;
            end
            if (xfer && (state_q == GET_HI)) begin
                word_q <= place_byte(word_q, byte_data, 1'b1);
            end
            if (xfer && (state_q == GET_LO)) begin
                word_q <= place_byte(word_q, byte_data, 1'b0);
            end
            // A mismatch leaves pointer, count and checksum untouched.
            if ((state_q == CHECK) && match) begin
                sum_q   <= sum_q + word_q;
                count_q <= count_next;
                ptr_q   <= ptr_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from the current state
    // ------------------------------------------------------------------
    assign byte_ready = (state_q == GET_HI) || (state_q == GET_LO);
    assign en_b       = (state_q == WRITE) || (state_q == READ);
    assign we_b       = (state_q == WRITE);
    assign busy       = (state_q == GET_HI) || (state_q == GET_LO) ||
                        (state_q == WRITE)  || (state_q == READ)   ||
                        (state_q == CHECK);
    assign done       = (state_q == DONE);
    assign error      = (state_q == ERROR);

    // Address and data are only meaningful while en_b is high; they simply
    // follow the pointer and assembled word, both zero after reset.
    assign addr_b        = ptr_q;
    assign din_b         = word_q;
    assign words_written = count_q;
    assign checksum      = sum_q;

endmodule

// File: doc/bram_loader.md
BRAM_LOADER -- requirements
Module: bram_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, the BRAM address width (depth 2^ADDR_WIDTH words of 16 bits).
REQ-002 SHALL have ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse that begins a load.
- len  in  ADDR_WIDTH+1  number of words to load; values above 2^ADDR_WIDTH are clamped to 2^ADDR_WIDTH.
- byte_valid  in  1  upstream byte available.
- byte_data  in  8  upstream byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- en_b  out  1  BRAM port enable.
- we_b  out  1  BRAM port write enable.
- addr_b  out  ADDR_WIDTH  BRAM port address.
- din_b  out  16  BRAM write data.
- dout_b  in  16  BRAM registered read data, one-cycle latency.
- busy  out  1  load in progress.
- done  out  1  load completed successfully (level).
- error  out  1  readback mismatch (level).
- words_written  out  ADDR_WIDTH+1  count of verified words.
- checksum  out  16  modulo-2^16 sum of verified words.

Function
REQ-003 SHALL implement FSM states IDLE, GET_HI, GET_LO, WRITE, READ, CHECK, DONE, ERROR.
REQ-004 SHALL transition IDLE/DONE/ERROR -> GET_HI on start with clamped len != 0, clearing the address pointer, words_written and checksum and latching the clamped len.
REQ-005 SHALL transition IDLE/DONE/ERROR -> DONE on start with len == 0, with words_written=0 and checksum=0.
REQ-006 SHALL ignore start while busy.
REQ-007 SHALL assert byte_ready only in GET_HI and GET_LO; a byte transfers when byte_valid and byte_ready are both high.
REQ-008 On transfer in GET_HI, SHALL latch the byte as word[15:8] and go to GET_LO; on transfer in GET_LO, SHALL latch it as word[7:0] and go to WRITE (big-endian byte order).
REQ-009 In WRITE, SHALL drive en_b=1, we_b=1, addr_b=pointer, din_b=word, then go to READ.
REQ-010 In READ, SHALL drive en_b=1, we_b=0, addr_b=pointer, then go to CHECK.
REQ-011 In CHECK, SHALL compare dout_b with word.
- On mismatch: go to ERROR; pointer, words_written and checksum are unchanged.
- On match: checksum += word (mod 2^16), words_written += 1, pointer += 1 (wraps modulo 2^ADDR_WIDTH).
- After a match: go to DONE if the new words_written equals the latched len, else go to GET_HI.
REQ-012 SHALL drive en_b=0 and we_b=0 in all states except WRITE and READ; addr_b and din_b are don't-care when en_b=0.
REQ-013 SHALL assert busy in GET_HI, GET_LO, WRITE, READ and CHECK; done only in DONE; error only in ERROR.
REQ-014 SHALL keep done and error asserted until rst or an accepted start.
REQ-015 SHALL take a minimum of 5 cycles per word (2 byte transfers + WRITE + READ + CHECK); upstream stalls add cycles only in GET_HI/GET_LO.
REQ-016 SHALL hold words_written and checksum stable outside CHECK and outside an accepted start.

Reset
REQ-017 On rst, SHALL go to IDLE with byte_ready=0, en_b=0, we_b=0, addr_b=0, din_b=0, busy=0, done=0, error=0, words_written=0, checksum=0 and pointer=0.
REQ-018 An rst asserted mid-load SHALL abort the load on the next edge; BRAM contents already written are retained.
REQ-019 rst SHALL take priority over start.

Structure
REQ-020 SHALL place the FSM state encoding and the byte-order constant in a shared package loader_pkg.
REQ-021 SHALL be a single module with no sub-modules; it connects to port B of the dual-port 16-bit BRAM.

Verification
REQ-022 Bench SHALL cover: len=3, bytes 12 34 AB CD 00 01 -> mem[0..2]=1234,ABCD,0001, done=1, words_written=3, checksum=BE02.
REQ-023 Bench SHALL cover: byte_valid held low for 7 cycles between hi and lo bytes -> no BRAM write during the stall; word written correctly after the stall.
REQ-024 Bench SHALL cover: force dout_b=0000 during CHECK of word 2 (of 4) -> error=1, words_written=1, done=0, byte_ready=0.
REQ-025 Bench SHALL cover: len=0 with start -> done on the next cycle, no en_b pulses.
REQ-026 Bench SHALL cover: len=1023 with ADDR_WIDTH=9 -> clamped to 512, addresses 0..511, done after 512 words.
REQ-027 Bench SHALL cover: rst asserted in READ of word 5 -> IDLE next cycle, all outputs at reset values; a following start with len=2 reloads from address 0.
